// File: rtl/tank_tread_ctrl_pkg.sv
// tank_ctrl_pkg: direction indices, tread code type and stick-to-tread mapping helpers.
`default_nettype none

package tank_ctrl_pkg;

   localparam int DIR_UP    = 3;
   localparam int DIR_DOWN  = 2;
   localparam int DIR_LEFT  = 1;
   localparam int DIR_RIGHT = 0;

   typedef struct packed {
      logic lfw;
      logic lbk;
      logic rfw;
      logic rbk;
   } tread_t;

   // {U,D,L,R} -> {Lfw,Lbk,Rfw,Rbk}; opposing pairs and 3+ bits fall to idle.
   function automatic tread_t map_8way(input logic [3:0] dir);
      tread_t t;
      case (dir)
         4'b1000: t = tread_t'(4'b1010);
         4'b1010: t = tread_t'(4'b0010);
         4'b1001: t = tread_t'(4'b1000);
         4'b0001: t = tread_t'(4'b1001);
         4'b0101: t = tread_t'(4'b0100);
         4'b0100: t = tread_t'(4'b0101);
         4'b0110: t = tread_t'(4'b0001);
         4'b0010: t = tread_t'(4'b0110);
         default: t = tread_t'(4'b0000);
      endcase
      return t;
   endfunction

   // a_ud / b_ud are {up,down} of the left and right sticks respectively.
   function automatic tread_t map_dual(input logic [1:0] a_ud, input logic [1:0] b_ud);
      tread_t t;
      t.lfw = a_ud[1] & ~a_ud[0];
      t.lbk = a_ud[0] & ~a_ud[1];
      t.rfw = b_ud[1] & ~b_ud[0];
      t.rbk = b_ud[0] & ~b_ud[1];
      return t;
   endfunction

endpackage

`default_nettype wire

// File: rtl/tank_tread_ctrl_debounce.sv
// input_debounce: per-bit stability filter counted in ce ticks; TICKS=0 passes the registered input.
`default_nettype none

module input_debounce #(
   parameter int WIDTH = 1,
   parameter int TICKS = 4
) (
   input  logic             clk_sys,
   input  logic             reset_n,
   input  logic             ce,
   input  logic [WIDTH-1:0] raw,
   output logic [WIDTH-1:0] stable
);

   logic [WIDTH-1:0] raw_q;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) raw_q <= '0;
      else          raw_q <= raw;
   end

   generate
      if (TICKS == 0) begin : g_bypass
         logic [WIDTH-1:0] acc_q;
         always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) acc_q <= '0;
            else          acc_q <= raw_q;
         end
         assign stable = acc_q;
      end else begin : g_filter
         localparam int CW = $clog2(TICKS + 1);
         for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            logic          acc_q;
            logic [CW-1:0] cnt_q;
            // A disagreeing ce that completes the run commits the new level.
            always_ff @(posedge clk_sys or negedge reset_n) begin
               if (!reset_n) begin
                  acc_q <= 1'b0;
                  cnt_q <= '0;
               end else if (ce) begin
                  if (raw_q[i] != acc_q) begin
                     if (cnt_q == CW'(TICKS - 1)) begin
                        acc_q <= raw_q[i];
                        cnt_q <= '0;
                     end else begin
                        cnt_q <= cnt_q + 1'b1;
                     end
                  end else begin
                     cnt_q <= '0;
                  end
               end
            end
            assign stable[i] = acc_q;
         end
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/tank_tread_ctrl.sv
// tank_tread_ctrl: debounced joystick to two-tread fw/bk levels with dual-stick mode and autofire.
`default_nettype none

module tank_tread_ctrl
   import tank_ctrl_pkg::*;
#(
   parameter int NUM_PLAYERS = 2,
   parameter int DEB_TICKS   = 4,
   parameter int AF_HALF     = 6
) (
   input  logic                     clk_sys,
   input  logic                     Reset_n,
   input  logic                     ce,
   input  logic [4*NUM_PLAYERS-1:0] joy_a,
   input  logic [4*NUM_PLAYERS-1:0] joy_b,
   input  logic [NUM_PLAYERS-1:0]   fire_in,
   input  logic [NUM_PLAYERS-1:0]   dual_mode,
   input  logic [NUM_PLAYERS-1:0]   af_en,
   output logic [2*NUM_PLAYERS-1:0] tread_fw,
   output logic [2*NUM_PLAYERS-1:0] tread_bk,
   output logic [NUM_PLAYERS-1:0]   fire_out
);

   localparam int AFW = $clog2(AF_HALF + 1);

   logic [4*NUM_PLAYERS-1:0] acc_a;
   logic [4*NUM_PLAYERS-1:0] acc_b;
   logic [NUM_PLAYERS-1:0]   acc_fire;

   input_debounce #(.WIDTH(4*NUM_PLAYERS), .TICKS(DEB_TICKS)) u_deb_a (
      .clk_sys(clk_sys), .reset_n(Reset_n), .ce(ce), .raw(joy_a), .stable(acc_a)
   );

   input_debounce #(.WIDTH(4*NUM_PLAYERS), .TICKS(DEB_TICKS)) u_deb_b (
      .clk_sys(clk_sys), .reset_n(Reset_n), .ce(ce), .raw(joy_b), .stable(acc_b)
   );

   input_debounce #(.WIDTH(NUM_PLAYERS), .TICKS(DEB_TICKS)) u_deb_fire (
      .clk_sys(clk_sys), .reset_n(Reset_n), .ce(ce), .raw(fire_in), .stable(acc_fire)
   );

   generate
      for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
         tread_t         code;
         logic [1:0]     fw_q;
         logic [1:0]     bk_q;
         logic           fire_q;
         logic           af_low;
         logic [AFW-1:0] af_cnt;
         logic           unused_b_lr;

         assign unused_b_lr = acc_b[4*p + DIR_LEFT] ^ acc_b[4*p + DIR_RIGHT];

         always_comb begin
            code = tread_t'(4'b0000);
            if (dual_mode[p])
               code = map_dual({acc_a[4*p + DIR_UP], acc_a[4*p + DIR_DOWN]},
                               {acc_b[4*p + DIR_UP], acc_b[4*p + DIR_DOWN]});
            else
               code = map_8way(acc_a[4*p +: 4]);
         end

         always_ff @(posedge clk_sys or negedge Reset_n) begin
            if (!Reset_n) begin
               fw_q <= 2'b00;
               bk_q <= 2'b00;
            end else begin
               fw_q <= {code.rfw, code.lfw};
               bk_q <= {code.rbk, code.lbk};
            end
         end

         // af_low cleared means the high half, so every fresh press starts high.
         always_ff @(posedge clk_sys or negedge Reset_n) begin
            if (!Reset_n) begin
               fire_q <= 1'b0;
               af_low <= 1'b0;
               af_cnt <= '0;
            end else if (!acc_fire[p]) begin
               fire_q <= 1'b0;
               af_low <= 1'b0;
               af_cnt <= '0;
            end else if (!af_en[p]) begin
               fire_q <= 1'b1;
               af_low <= 1'b0;
               af_cnt <= '0;
            end else begin
               fire_q <= ~af_low;
               if (ce) begin
                  if (af_cnt == AFW'(AF_HALF - 1)) begin
                     af_cnt <= '0;
                     af_low <= ~af_low;
                  end else begin
                     af_cnt <= af_cnt + 1'b1;
                  end
               end
            end
         end

         assign tread_fw[2*p +: 2] = fw_q;
         assign tread_bk[2*p +: 2] = bk_q;
         assign fire_out[p]        = fire_q;
      end
   endgenerate

endmodule

`default_nettype wire

// File: doc/tank_tread_ctrl.md
Name: tank_tread_ctrl

Overview:
- Converts per-player digital joystick inputs into the two-level tread controls used by tank-style arcade cores (forward/back per tread, two treads per player).
- Generalises the existing fixed two-player 8-way-stick table to NUM_PLAYERS channels.
- Adds per-input debounce, a per-player dual-stick mode, and per-player autofire.
- Sits in the emu top, between the merged keyboard/USB/DB9 button signals and the game core's active-low joystick inputs; the top inverts the outputs.

Parameters:
- NUM_PLAYERS, 2, number of independent player channels (1..4).
- DEB_TICKS, 4, ce ticks an input must be stable before it is accepted; 0 bypasses debounce.
- AF_HALF, 6, autofire half-period in ce ticks (>=1).

Ports:
- clk_sys  in  1  system clock
- Reset_n  in  1  asynchronous, active-low reset
- ce  in  1  sampling tick enable (~1 kHz strobe from top), one clk_sys cycle wide
- joy_a  in  4*NUM_PLAYERS  primary stick {up,down,left,right} per player, player p at [4p+3:4p], active-high
- joy_b  in  4*NUM_PLAYERS  secondary stick, same packing; used only in dual-stick mode
- fire_in  in  NUM_PLAYERS  fire button per player, active-high
- dual_mode  in  NUM_PLAYERS  1 = dual-stick mode for that player, 0 = 8-way mapping
- af_en  in  NUM_PLAYERS  autofire enable per player
- tread_fw  out  2*NUM_PLAYERS  forward level; bit 2p = left tread (W/Y), 2p+1 = right tread (X/Z)
- tread_bk  out  2*NUM_PLAYERS  backward level, same packing
- fire_out  out  NUM_PLAYERS  fire to core, active-high

Behaviour:
- Reset: all outputs 0; debounced states 0; debounce counters, autofire counters and phases cleared. Reset asserted mid-operation clears everything immediately (async); the first ce after release starts fresh.
- Debounce, per bit (joy_a, joy_b, fire_in):
  - Raw input registered on every clk_sys.
  - On ce: if raw != accepted, count++; when count reaches DEB_TICKS, accepted <= raw and count <= 0.
  - If raw == accepted on a ce, count <= 0.
  - A glitch shorter than DEB_TICKS ce ticks never reaches the accepted state.
  - DEB_TICKS = 0: accepted follows the registered raw value every clock.
- 8-way mapping (dual_mode = 0), on accepted {U,D,L,R} -> {Lfw,Lbk,Rfw,Rbk}:
  - 1000 up -> 1010
  - 1010 up-left -> 0010
  - 1001 up-right -> 1000
  - 0001 right -> 1001
  - 0101 down-right -> 0100
  - 0100 down -> 0101
  - 0110 down-left -> 0001
  - 0010 left -> 0110
  - any other code, including idle, opposing pairs and three or more bits -> 0000
- Dual-stick mode (dual_mode = 1): left tread from joy_a up/down, right tread from joy_b up/down; fw = up & ~down, bk = down & ~up. Left/right bits ignored; up+down on one stick -> both 0 for that tread.
- Invariant: tread_fw[i] & tread_bk[i] is never 1.
- Tread outputs are registered: one clk_sys after the accepted state (or dual_mode) changes. Mode switching never produces a fw&bk pair.
- Autofire:
  - af_en = 0: fire_out = accepted fire, registered, 1 clk latency.
  - af_en = 1 with fire accepted high: fire_out asserts on the next clock, then toggles every AF_HALF ce ticks (50% duty, period 2*AF_HALF ticks).
  - Fire release: fire_out <= 0 next clock; phase counter resets so the next press starts high.
  - af_en dropping while held: fire_out = 1 steady from the next clock.
- Counter widths: $clog2(DEB_TICKS+1) and $clog2(AF_HALF+1); no wrap is possible because counters saturate at their compare value and reload.
- Players are fully independent; simultaneous events on different players are processed in the same cycle.

Decomposition:
- Package tank_ctrl_pkg holds:
  - direction index constants (DIR_UP=3, DIR_DOWN=2, DIR_LEFT=1, DIR_RIGHT=0)
  - tread code typedef (struct: lfw, lbk, rfw, rbk)
  - 8-way mapping function
- Sub-module input_debounce (param WIDTH, TICKS) is instantiated once for joy_a, once for joy_b and once for fire_in. The mapping function and autofire logic sit inline in a generate-for over players.

Test Plan:
- DEB_TICKS=4: hold joy_a=4'b1000 for p0 -> tread_fw[1:0]=2'b11, tread_bk=0 exactly 1 clk after the 4th ce; a 3-tick pulse produces no output change.
- Sweep all 16 codes on p1 with DEB_TICKS=0 -> outputs match the table (e.g. 0001 -> fw=2'b01, bk=2'b10 at bits [3:2]); codes 1100/0011/1111 -> 0.
- dual_mode=1, joy_a=up, joy_b=down -> fw[0]=1, bk[1]=1; set joy_a=up+down -> fw[0]=0, bk[0]=0.
- af_en=1, AF_HALF=6, hold fire -> fire_out high 6 ce ticks, low 6, high 6; release -> 0 next clock; re-press starts high.
- Assert Reset_n=0 mid-autofire with stick held -> all outputs 0 asynchronously; after release with inputs held, outputs reappear after DEB_TICKS ce ticks + 1 clk.
- NUM_PLAYERS=4: distinct stimulus per player simultaneously -> each player's outputs are independent and correct, with no cross-talk.
